// File: rtl/rcpu_core.sv
// rcpu_core: minimal 16-bit multi-cycle CPU core.
// Four 16-bit GPRs, Z/C flags, 16-bit word-addressed PC, one asynchronous
// read-only memory port shared by instruction fetch and LD.
// Every instruction takes one FETCH cycle and one EXEC cycle; HLT parks the
// core in HALT until reset.
// Optional build macro RCPU_DEBUG_EN adds dbgSel/dbgData/dbgPc observation
// ports; without it the core is complete and behaves identically.

module rcpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] memAddr,
  input  logic [15:0] memRead,
  output logic        halted
`ifdef RCPU_DEBUG_EN
  ,
  input  logic [1:0]  dbgSel,
  output logic [15:0] dbgData,
  output logic [15:0] dbgPc
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_LDH = 4'h2, OP_MOV  = 4'h3,
    OP_ADD  = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR   = 4'h7,
    OP_XOR  = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_LD   = 4'hB,
    OP_BCC  = 4'hC, OP_ADDI = 4'hD, OP_HLT = 4'hE, OP_RSV = 4'hF
  } op_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] gpr [4];
  logic        z_flag;
  logic        c_flag;

  // Instruction fields decoded from the latched IR.
  op_t         op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm8;
  logic [15:0] sext_imm;
  logic [15:0] rd_val;
  logic [15:0] rs_val;

  assign op       = op_t'(ir[15:12]);
  assign rd       = ir[11:10];
  assign rs       = ir[9:8];
  assign imm8     = ir[7:0];
  assign sext_imm = {{8{imm8[7]}}, imm8};
  assign rd_val   = gpr[rd];
  assign rs_val   = gpr[rs];

  // ALU results for the EXEC cycle.
  logic [15:0] alu_res;
  logic        alu_c;
  logic        rd_wr;
  logic        flag_wr;
  logic        br_take;

  // Compute the destination value, carry and write enables from the IR.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and a latch is inferred; combinational blocks use blocking assignments.
    alu_res = rd_val;
    alu_c   = c_flag;
    rd_wr   = 1'b0;
    flag_wr = 1'b0;
    br_take = 1'b0;
    case (op)
      OP_LDI:  begin alu_res = {8'h00, imm8};          rd_wr = 1'b1; end
      OP_LDH:  begin alu_res = {imm8, rd_val[7:0]};    rd_wr = 1'b1; end
      OP_MOV:  begin alu_res = rs_val;                 rd_wr = 1'b1; end
      OP_ADD:  begin
        {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
        rd_wr = 1'b1; flag_wr = 1'b1;
      end
      // Bit 16 of the widened difference is the borrow (rd < rs unsigned).
      OP_SUB:  begin
        {alu_c, alu_res} = {1'b0, rd_val} - {1'b0, rs_val};
        rd_wr = 1'b1; flag_wr = 1'b1;
      end
      OP_AND:  begin alu_res = rd_val & rs_val; rd_wr = 1'b1; flag_wr = 1'b1; end
      OP_OR:   begin alu_res = rd_val | rs_val; rd_wr = 1'b1; flag_wr = 1'b1; end
      OP_XOR:  begin alu_res = rd_val ^ rs_val; rd_wr = 1'b1; flag_wr = 1'b1; end
      OP_SHL:  begin {alu_c, alu_res} = {rd_val, 1'b0}; rd_wr = 1'b1; flag_wr = 1'b1; end
      OP_SHR:  begin {alu_res, alu_c} = {1'b0, rd_val}; rd_wr = 1'b1; flag_wr = 1'b1; end
      OP_LD:   begin alu_res = memRead; rd_wr = 1'b1; end
      OP_ADDI: begin
        {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, sext_imm};
        rd_wr = 1'b1; flag_wr = 1'b1;
      end
      // Branch condition lives in the rd field.
      OP_BCC: begin
        case (rd)
          2'b00:   br_take = 1'b1;
          2'b01:   br_take = z_flag;
          2'b10:   br_take = ~z_flag;
          default: br_take = c_flag;
        endcase
      end
      default: ;
    endcase
  end

  // Memory address: the PC everywhere except the EXEC cycle of LD.
  always_comb begin
    memAddr = pc;
    if (state == S_EXEC && op == OP_LD) memAddr = rs_val;
  end

  // Core state machine: fetch, execute, halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= 16'h0000;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      halted <= 1'b0;
      // NOTE: the register file is cleared on reset because software may read
      // any GPR before writing it; four words of flops make this cheap.
      for (int i = 0; i < 4; i++) gpr[i] <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; ADD R1,R1 therefore sees the old R1 on both operands.
      case (state)
        S_FETCH: begin
          ir    <= memRead;
          pc    <= pc + 16'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (rd_wr) gpr[rd] <= alu_res;
          if (flag_wr) begin
            z_flag <= (alu_res == 16'h0000);
            c_flag <= alu_c;
          end
          if (br_take) pc <= pc + sext_imm;
          if (op == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef RCPU_DEBUG_EN
  // Debug observation of the register file and PC.
  assign dbgData = gpr[dbgSel];
  assign dbgPc   = pc;
`endif

endmodule

// File: tb/tb_rcpu_core.sv
// tb_rcpu_core: self-checking bench for rcpu_core.
// An instruction-level reference model predicts, per instruction, the fetch
// address, the EXEC-cycle memory address and the halt point. Registers and
// flags are made visible through the memory port (LD puts rs on memAddr,
// branches change the fetch sequence). Directed programs pin known values;
// random programs over random memory exercise the rest.

module tb_rcpu_core;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic [15:0] mem_read;
  logic        halted;
`ifdef RCPU_DEBUG_EN
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [15:0] dbg_pc;
  assign dbg_sel = 2'd0;
`endif

  // Asynchronous read memory, 64K words.
  logic [15:0] mem [0:65535];
  assign mem_read = mem[mem_addr];

  rcpu_core #(.RESET_PC(16'h0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .memAddr (mem_addr),
    .memRead (mem_read),
    .halted  (halted)
`ifdef RCPU_DEBUG_EN
    ,
    .dbgSel  (dbg_sel),
    .dbgData (dbg_data),
    .dbgPc   (dbg_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [15:0] m_r [4];
  logic [15:0] m_pc;
  logic        m_z;
  logic        m_c;
  logic        m_halt;

  logic [15:0] fetch_seen [$];
  logic [15:0] ld_seen [$];
  int          halt_edge;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Execute one instruction at ISA level; returns the address the core must
  // present during that instruction's EXEC cycle.
  task automatic model_exec(input logic [15:0] instr, output logic [15:0] exec_addr);
    int unsigned a, b, res;
    int          off;
    bit          alu, take;
    logic [1:0]  rd, rs;
    rd   = instr[11:10];
    rs   = instr[9:8];
    a    = m_r[rd];
    b    = m_r[rs];
    off  = instr[7] ? int'(instr[7:0]) - 256 : int'(instr[7:0]);
    m_pc = m_pc + 16'd1;
    exec_addr = (instr[15:12] == 4'hB) ? m_r[rs] : m_pc;
    alu  = 1'b0;
    take = 1'b0;
    res  = 0;
    case (instr[15:12])
      4'h1: m_r[rd] = {8'h00, instr[7:0]};
      4'h2: m_r[rd][15:8] = instr[7:0];
      4'h3: m_r[rd] = m_r[rs];
      4'h4: begin res = a + b;          m_c = (res > 65535); alu = 1'b1; end
      4'h5: begin res = a + 65536 - b;  m_c = (a < b);       alu = 1'b1; end
      4'h6: begin res = a & b; alu = 1'b1; end
      4'h7: begin res = a | b; alu = 1'b1; end
      4'h8: begin res = a ^ b; alu = 1'b1; end
      4'h9: begin res = a * 2; m_c = (a >= 32768);  alu = 1'b1; end
      4'hA: begin res = a / 2; m_c = (a % 2 == 1);  alu = 1'b1; end
      4'hB: m_r[rd] = mem[m_r[rs]];
      4'hC: begin
        case (rd)
          2'd0: take = 1'b1;
          2'd1: take = m_z;
          2'd2: take = !m_z;
          default: take = m_c;
        endcase
        if (take) m_pc = 16'(int'(m_pc) + off);
      end
      4'hD: begin
        res = a + ((off + 65536) % 65536);
        m_c = (res > 65535);
        alu = 1'b1;
      end
      4'hE: m_halt = 1'b1;
      default: ;
    endcase
    if (alu) begin
      m_r[rd] = res[15:0];
      m_z = ((res % 65536) == 0);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
  endtask

  task automatic random_mem();
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    // Thin out HLT near the start so programs run for a while.
    for (int a = 0; a < 512; a++)
      if (mem[a][15:12] == 4'hE && $urandom_range(0, 3) != 0) mem[a][15:12] = 4'hD;
  endtask

  // Reset the core mid-cycle, then run up to max_instr instructions
  // comparing every cycle against the model. With abort_mid the last
  // instruction is cut off by the next reset after its FETCH.
  task automatic run_prog(input int max_instr, input bit abort_mid);
    logic [15:0] instr, ea;
    int cyc;
    fetch_seen.delete();
    ld_seen.delete();
    halt_edge = -1;
    m_pc = 16'h0000;
    m_r = '{default: 16'h0000};
    m_z = 1'b0;
    m_c = 1'b0;
    m_halt = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_halted", {15'b0, halted}, 16'h0000);
    rst = 1'b0;
    #1;
    cyc = 0;
    for (int n = 0; n < max_instr; n++) begin
      check("fetch_addr", mem_addr, m_pc);
      check("fetch_halted", {15'b0, halted}, 16'h0000);
      fetch_seen.push_back(mem_addr);
      instr = mem[m_pc];
      model_exec(instr, ea);
      @(posedge clk); #1; cyc++;
      if (abort_mid && n == max_instr - 1) break;
      check("exec_addr", mem_addr, ea);
      check("exec_halted", {15'b0, halted}, 16'h0000);
      if (instr[15:12] == 4'hB) ld_seen.push_back(mem_addr);
      @(posedge clk); #1; cyc++;
      if (m_halt) begin
        halt_edge = cyc;
        for (int k = 0; k < 20; k++) begin
          check("halt_addr", mem_addr, m_pc);
          check("halt_flag", {15'b0, halted}, 16'h0001);
          @(posedge clk); #1;
        end
        break;
      end
    end
  endtask

  initial begin
    int cnt;
    n_cmp  = 0;
    n_fail = 0;

    // Reset state: every GPR read back through LD must be 0, Z and C clear.
    clear_mem();
    mem[0] = 16'hB000;  // LD R0,[R0]
    mem[1] = 16'hB500;  // LD R1,[R1]
    mem[2] = 16'hBA00;  // LD R2,[R2]
    mem[3] = 16'hBF00;  // LD R3,[R3]
    mem[4] = 16'hC402;  // BZ +2
    mem[5] = 16'hCC01;  // BC +1
    mem[6] = 16'hE000;  // HLT
    mem[7] = 16'hE000;  // HLT
    run_prog(20, 1'b0);
    check("rst_ld_count", 16'(ld_seen.size()), 16'd4);
    for (int i = 0; i < ld_seen.size(); i++) check("rst_reg_zero", ld_seen[i], 16'h0000);
    check("rst_end_pc", mem_addr, 16'h0007);

    // ALU program: halted rises on the 10th rising edge.
    clear_mem();
    mem[0] = 16'h1005;  // LDI R0,5
    mem[1] = 16'h1403;  // LDI R1,3
    mem[2] = 16'h4100;  // ADD R0,R1
    mem[3] = 16'h5400;  // SUB R1,R0
    mem[4] = 16'hE000;  // HLT
    run_prog(20, 1'b0);
    check("alu_halt_edge", 16'(halt_edge), 16'd10);
    check("alu_end_pc", mem_addr, 16'h0005);

    // Same program with results exposed: R0=8, R1=3-8=FFFB, C=1, Z=0.
    mem[4] = 16'hB800;  // LD R2,[R0]
    mem[5] = 16'hB900;  // LD R2,[R1]
    mem[6] = 16'hCC01;  // BC +1  (taken)
    mem[7] = 16'hE000;
    mem[8] = 16'hC401;  // BZ +1  (not taken)
    mem[9] = 16'hE000;
    run_prog(20, 1'b0);
    check("alu_ld_count", 16'(ld_seen.size()), 16'd2);
    check("alu_r0", ld_seen[0], 16'h0008);
    check("alu_r1", ld_seen[1], 16'hFFFB);
    check("alu_end_pc_flags", mem_addr, 16'h000A);

    // LDH and shifts: 2468 after SHL, 1234 after SHR, C=0 both times.
    clear_mem();
    mem[0] = 16'h1834;  // LDI R2,0x34
    mem[1] = 16'h2812;  // LDH R2,0x12
    mem[2] = 16'h9800;  // SHL R2
    mem[3] = 16'hBE00;  // LD R3,[R2]
    mem[4] = 16'hCC01;  // BC +1
    mem[5] = 16'hA800;  // SHR R2
    mem[6] = 16'hBE00;  // LD R3,[R2]
    mem[7] = 16'hCC01;  // BC +1
    mem[8] = 16'hE000;
    run_prog(20, 1'b0);
    check("shl_val", ld_seen[0], 16'h2468);
    check("shr_val", ld_seen[1], 16'h1234);
    check("shift_end_pc", mem_addr, 16'h0009);

    // Memory load: LD EXEC presents 0040, R0 becomes ABCD.
    clear_mem();
    mem[16'h0040] = 16'hABCD;
    mem[0] = 16'h1C40;  // LDI R3,0x40
    mem[1] = 16'hB300;  // LD R0,[R3]
    mem[2] = 16'hB400;  // LD R1,[R0]
    mem[3] = 16'hE000;
    run_prog(20, 1'b0);
    check("ld_addr", ld_seen[0], 16'h0040);
    check("ld_data", ld_seen[1], 16'hABCD);
    check("ld_end_pc", mem_addr, 16'h0004);

    // Countdown loop: ADDI runs 3 times, exit on Z=1, HLT leaves PC=0004.
    clear_mem();
    mem[0] = 16'h1003;  // LDI R0,3
    mem[1] = 16'hD0FF;  // ADDI R0,-1
    mem[2] = 16'hC8FE;  // BNZ -2
    mem[3] = 16'hE000;
    run_prog(40, 1'b0);
    cnt = 0;
    foreach (fetch_seen[i]) if (fetch_seen[i] == 16'h0001) cnt++;
    check("loop_addi_count", 16'(cnt), 16'd3);
    check("loop_end_pc", mem_addr, 16'h0004);

    // Always-branch with offset 0 falls through.
    clear_mem();
    mem[0] = 16'hC000;  // BRA +0
    mem[1] = 16'hE000;
    run_prog(10, 1'b0);
    check("bra0_fetch1", fetch_seen[1], 16'h0001);
    check("bra0_end_pc", mem_addr, 16'h0002);

    // PC wrap in both directions: 0000 -> FFFF -> 0000+1.
    clear_mem();
    mem[0]          = 16'hC0FE;  // BRA -2  -> FFFF
    mem[16'hFFFF]   = 16'hC001;  // BRA +1  -> 0001
    mem[1]          = 16'hE000;
    run_prog(10, 1'b0);
    check("wrap_fetch1", fetch_seen[1], 16'hFFFF);
    check("wrap_fetch2", fetch_seen[2], 16'h0001);
    check("wrap_end_pc", mem_addr, 16'h0002);

    // Random programs over random memory, some cut off by reset mid-instruction.
    for (int r = 0; r < 8; r++) begin
      random_mem();
      run_prog(150, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
